// File: rtl/gen_pipe_dffr_pkg.sv
// ----------------------------------------------------------------------------
// gen_pipe_dffr_pkg
//
// Shared types for the elastic pipeline register.
//
// Contents:
//   pipe_op_e   - what happens to the occupancy counter on a clock edge
//   classify_op - turns the two handshake fire bits into a pipe_op_e
// ----------------------------------------------------------------------------
package gen_pipe_dffr_pkg;

    // Occupancy update selected by the enqueue/dequeue fire bits.
    // The encoding is {enq_fire, deq_fire} so the enum can be built directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } pipe_op_e;

    function automatic pipe_op_e classify_op(input logic enq_fire,
                                             input logic deq_fire);
        return pipe_op_e'({enq_fire, deq_fire});
    endfunction

endpackage

// File: rtl/gen_pipe_stage.sv
// ----------------------------------------------------------------------------
// gen_pipe_stage
//
// One stage of the elastic pipeline: a valid flag plus a DW-bit data register.
// The data register only loads when the stage accepts a new item, so idle
// bubbles do not toggle the datapath.
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous active-high reset (valid=0, data=rstValue)
//   flush    in   synchronous clear of the valid flag; data holds
//   load     in   stage accepts d_in this cycle (sets valid)
//   clear    in   stage hands its item on with nothing arriving (clears valid)
//   d_in     in   incoming payload
//   v_q      out  stage holds valid data
//   d_q      out  stage payload
// ----------------------------------------------------------------------------
module gen_pipe_stage #(
    parameter int             DW       = 32,
    parameter logic [DW-1:0]  rstValue = {DW{1'b0}}
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d_in,
    output logic          v_q,
    output logic [DW-1:0] d_q
);

    // Valid flag: flush wins over everything, a load wins over a clear
    // because an item arriving replaces the one that leaves.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q <= 1'b0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (load) begin
            v_q <= 1'b1;
        end else if (clear) begin
            v_q <= 1'b0;
        end
    end

    // Data register: loads only on an accepted transfer and never during a
    // flush, so the last payload stays visible after the pipe is emptied.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_q <= rstValue;
        end else if (load && !flush) begin
            d_q <= d_in;
        end
    end

endmodule

// File: rtl/gen_pipe_dffr.sv
// ----------------------------------------------------------------------------
// gen_pipe_dffr
//
// Parametrised elastic pipeline register: DEPTH stages of DW-bit data, each
// with a valid bit, valid/ready handshake at both ends, bubble collapse and a
// synchronous flush. Stage 0 is the input stage, stage DEPTH-1 drives the
// output. Items never overtake one another.
//
// Parameters:
//   DW        data width
//   DEPTH     number of stages (1 or more)
//   rstValue  reset value of every stage data register
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   flush      in   synchronous clear of all stages and the counter
//   enq_valid  in   upstream offers enq_data
//   enq_ready  out  pipeline accepts this cycle
//   enq_data   in   input payload
//   deq_valid  out  output stage holds valid data
//   deq_ready  in   downstream accepts this cycle
//   deq_data   out  output payload (always the output stage register)
//   count      out  number of valid stages
// ----------------------------------------------------------------------------
module gen_pipe_dffr
    import gen_pipe_dffr_pkg::*;
#(
    parameter int             DW       = 32,
    parameter int             DEPTH    = 2,
    parameter logic [DW-1:0]  rstValue = {DW{1'b0}},
    localparam int            CW       = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [DW-1:0] enq_data,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [DW-1:0] deq_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] stage_load;
    logic [DEPTH-1:0] stage_clear;
    logic [DW-1:0]    d        [DEPTH];
    logic [DW-1:0]    stage_in [DEPTH];
    logic             enq_fire;
    logic             deq_fire;

    // Advance chain, evaluated from the output stage backwards: a stage moves
    // when it is valid and the next stage is either empty or moving itself.
    // This gives the deq_ready -> enq_ready path its DEPTH-long ripple.
    always_comb begin
        move = '0;
        move[DEPTH-1] = v[DEPTH-1] & deq_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            move[i] = v[i] & (~v[i+1] | move[i+1]);
        end
    end

    // Handshake at both ends; flush blocks both so nothing transfers on a
    // flushing edge.
    always_comb begin
        enq_ready = ~flush & (~v[0] | move[0]);
        enq_fire  = enq_valid & enq_ready;
        deq_valid = v[DEPTH-1] & ~flush;
        deq_fire  = deq_valid & deq_ready;
        deq_data  = d[DEPTH-1];
    end

    // Per-stage load/clear: stage 0 is fed by the enqueue port, every later
    // stage by its predecessor moving. A stage only drops its valid flag when
    // it moves and nothing moves in behind it.
    always_comb begin
        stage_load  = '0;
        stage_clear = '0;
        stage_in[0] = enq_data;
        stage_load[0] = enq_fire;
        for (int i = 1; i < DEPTH; i++) begin
            stage_in[i]   = d[i-1];
            stage_load[i] = move[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            stage_clear[i] = move[i] & ~stage_load[i];
        end
    end

    // The stage chain itself.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        gen_pipe_stage #(
            .DW       (DW),
            .rstValue (rstValue)
        ) u_stage (
            .CLK   (CLK),
            .RST   (RST),
            .flush (flush),
            .load  (stage_load[i]),
            .clear (stage_clear[i]),
            .d_in  (stage_in[i]),
            .v_q   (v[i]),
            .d_q   (d[i])
        );
    end

    // Occupancy counter kept as its own register so count is a clean flop
    // output rather than a popcount tree; it tracks the fire bits exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case (classify_op(enq_fire, deq_fire))
                OP_ENQ:  count <= count + CW'(1);
                OP_DEQ:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The counter must always agree with the number of set valid flags.
    count_matches_valid: assert property (
        @(posedge CLK) disable iff (RST) int'(count) == $countones(v)
    );

endmodule

// File: tb/tb_gen_pipe_dffr.sv
// ----------------------------------------------------------------------------
// tb_gen_pipe_dffr
//
// Four instances of gen_pipe_dffr (DEPTH 3, 4, 1, 5) share one stimulus
// stream. A per-instance scoreboard records every accepted item and the
// monitor compares each dequeued item, the occupancy count, enq_ready and
// deq_valid against a small occupancy model. Directed sequences add
// hand-computed checks for latency, back-pressure, bubble collapse, flush
// and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_gen_pipe_dffr;

    localparam int NDUT = 4;
    localparam logic [31:0] RSTV0 = 32'hCAFE_0001;
    localparam logic [31:0] RSTV1 = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_data;
    logic        deq_ready;

    logic        enq_ready_w [NDUT];
    logic        deq_valid_w [NDUT];
    logic [31:0] deq_data_w  [NDUT];
    logic [7:0]  count_w     [NDUT];

    logic [1:0]  cnt_d3;
    logic [2:0]  cnt_d4;
    logic [0:0]  cnt_d1;
    logic [2:0]  cnt_d5;

    int          dep [NDUT] = '{3, 4, 1, 5};
    logic [31:0] sb  [NDUT][$];
    int          mcnt [NDUT];

    int n_vec  = 0;
    int n_miss = 0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    gen_pipe_dffr #(.DW(32), .DEPTH(3), .rstValue(RSTV0)) u_d3 (
        .CLK(clk), .RST(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready_w[0]), .enq_data(enq_data),
        .deq_valid(deq_valid_w[0]), .deq_ready(deq_ready), .deq_data(deq_data_w[0]),
        .count(cnt_d3));

    gen_pipe_dffr #(.DW(32), .DEPTH(4), .rstValue(RSTV1)) u_d4 (
        .CLK(clk), .RST(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready_w[1]), .enq_data(enq_data),
        .deq_valid(deq_valid_w[1]), .deq_ready(deq_ready), .deq_data(deq_data_w[1]),
        .count(cnt_d4));

    gen_pipe_dffr #(.DW(32), .DEPTH(1), .rstValue(RSTV1)) u_d1 (
        .CLK(clk), .RST(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready_w[2]), .enq_data(enq_data),
        .deq_valid(deq_valid_w[2]), .deq_ready(deq_ready), .deq_data(deq_data_w[2]),
        .count(cnt_d1));

    gen_pipe_dffr #(.DW(32), .DEPTH(5), .rstValue(RSTV1)) u_d5 (
        .CLK(clk), .RST(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready_w[3]), .enq_data(enq_data),
        .deq_valid(deq_valid_w[3]), .deq_ready(deq_ready), .deq_data(deq_data_w[3]),
        .count(cnt_d5));

    // Bring the differently sized counters onto one common width.
    always_comb begin
        count_w[0] = 8'(cnt_d3);
        count_w[1] = 8'(cnt_d4);
        count_w[2] = 8'(cnt_d1);
        count_w[3] = 8'(cnt_d5);
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic ev, input logic [31:0] data,
                                 input logic dr, input logic fl);
        @(posedge clk);
        #1;
        enq_valid = ev;
        enq_data  = data;
        deq_ready = dr;
        flush     = fl;
    endtask

    // Monitor: on every falling edge compare each instance against its
    // occupancy model, then account for the transfers about to happen at the
    // next rising edge. A full pipe must show its output, an empty one must
    // not, and enq_ready depends only on occupancy, deq_ready and flush.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                sb[k].delete();
                mcnt[k] = 0;
            end else begin
                checkOutput($sformatf("count_d%0d", dep[k]),
                            32'(count_w[k]), 32'(mcnt[k]));
                checkOutput($sformatf("enq_ready_d%0d", dep[k]),
                            32'(enq_ready_w[k]),
                            32'(!flush && (mcnt[k] < dep[k] || deq_ready)));
                if (flush || mcnt[k] == 0) begin
                    checkOutput($sformatf("deq_valid_low_d%0d", dep[k]),
                                32'(deq_valid_w[k]), 32'(0));
                end else if (mcnt[k] == dep[k]) begin
                    checkOutput($sformatf("deq_valid_full_d%0d", dep[k]),
                                32'(deq_valid_w[k]), 32'(1));
                end
                if (flush) begin
                    sb[k].delete();
                    mcnt[k] = 0;
                end else begin
                    if (deq_valid_w[k] && deq_ready && sb[k].size() > 0) begin
                        checkOutput($sformatf("deq_data_order_d%0d", dep[k]),
                                    deq_data_w[k], sb[k].pop_front());
                        mcnt[k]--;
                    end
                    if (enq_valid && enq_ready_w[k]) begin
                        sb[k].push_back(enq_data);
                        mcnt[k]++;
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_data  = 32'h0;
        deq_ready = 1'b0;

        // Reset state, including the flush -> enq_ready path during reset.
        #3;
        checkOutput("rst_deq_valid", 32'(deq_valid_w[0]), 32'(0));
        checkOutput("rst_count", 32'(count_w[0]), 32'(0));
        checkOutput("rst_deq_data_d3", deq_data_w[0], RSTV0);
        checkOutput("rst_deq_data_d4", deq_data_w[1], RSTV1);
        checkOutput("rst_enq_ready", 32'(enq_ready_w[0]), 32'(1));
        flush = 1'b1;
        #1;
        checkOutput("rst_enq_ready_flush", 32'(enq_ready_w[0]), 32'(0));
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming into DEPTH=3 with deq_ready high: item k+1 enters in
        // cycle k and appears three cycles later, one per cycle.
        for (int k = 0; k < 11; k++) begin
            applyStimulus(k < 8, 32'(k + 1), 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("stream_valid_c%0d", k),
                        32'(deq_valid_w[0]), 32'(k >= 3 && k <= 10));
            if (k >= 3 && k <= 10) begin
                checkOutput($sformatf("stream_data_c%0d", k),
                            deq_data_w[0], 32'(k - 2));
            end
        end
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: three items fill DEPTH=3, the fourth waits, then
        // releasing deq_ready lets 0x1 out and the fourth in on one edge.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'(k + 1), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_enq_ready_full", 32'(enq_ready_w[0]), 32'(0));
        checkOutput("bp_count_full", 32'(count_w[0]), 32'(3));
        applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_enq_ready_release", 32'(enq_ready_w[0]), 32'(1));
        checkOutput("bp_deq_valid_release", 32'(deq_valid_w[0]), 32'(1));
        checkOutput("bp_deq_data_release", deq_data_w[0], 32'h1);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Bubble collapse in DEPTH=4: items in cycles 0 and 2 with the output
        // stalled end up packed in stages 3 and 2, so they leave back-to-back.
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bubble_count_d4", 32'(count_w[1]), 32'(2));
        checkOutput("bubble_head_valid_d4", 32'(deq_valid_w[1]), 32'(1));
        checkOutput("bubble_head_data_d4", deq_data_w[1], 32'hA1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bubble_first_data_d4", deq_data_w[1], 32'hA1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bubble_second_valid_d4", 32'(deq_valid_w[1]), 32'(1));
        checkOutput("bubble_second_data_d4", deq_data_w[1], 32'hB2);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with two items held and an offer pending: nothing transfers,
        // the pipe empties and the output register keeps 0x11.
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_enq_ready", 32'(enq_ready_w[0]), 32'(0));
        checkOutput("flush_deq_valid", 32'(deq_valid_w[0]), 32'(0));
        checkOutput("flush_deq_data", deq_data_w[0], 32'h11);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("post_flush_count", 32'(count_w[0]), 32'(0));
        checkOutput("post_flush_deq_valid", 32'(deq_valid_w[0]), 32'(0));
        checkOutput("post_flush_deq_data", deq_data_w[0], 32'h11);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with two items held: outputs drop before the
        // next clock edge.
        applyStimulus(1'b1, 32'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h32, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_count", 32'(count_w[0]), 32'(2));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_deq_valid", 32'(deq_valid_w[0]), 32'(0));
        checkOutput("async_rst_count", 32'(count_w[0]), 32'(0));
        checkOutput("async_rst_deq_data", deq_data_w[0], RSTV0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random soak across all four depths; the monitor does the checking.
        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(0, 99) < 70, $urandom,
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 4);
        end
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
